bip_datapath: RTL and testbench

- Execution datapath of the BIP single-cycle processor. It sits directly downstream of the BIP control unit.
- Consumes the per-instruction control strobes and the 11-bit operand the control unit decodes each cycle.
- Holds the accumulator (ACC), the add/subtract ALU, the operand muxes and the data RAM.
- Stores and accumulator updates commit on the clock edge that ends the instruction cycle.

---
 rtl/bip_datapath_if.sv | 33 +++
 rtl/bip_datapath.sv | 78 +++++++
 tb/tb_bip_datapath.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bip_datapath_if.sv
// Control-unit to datapath bus of the BIP processor: per-instruction strobes,
// operand and debug address in; accumulator, overflow flag and debug word out.
interface bip_datapath_if #(
    parameter int NB_DATA          = 16,
    parameter int NB_OPERAND       = 11,
    parameter int LOG2_N_DATA_ADDR = 10,
    parameter int NB_SEL_A         = 2
);
    logic                        i_valid;
    logic [NB_SEL_A-1:0]         i_sel_a;
    logic                        i_sel_b;
    logic                        i_wr_acc;
    logic                        i_op_code;
    logic                        i_wr_ram;
    logic                        i_rd_ram;
    logic [NB_OPERAND-1:0]       i_operand;
    logic [LOG2_N_DATA_ADDR-1:0] i_dbg_addr;
    logic [NB_DATA-1:0]          o_acc;
    logic                        o_overflow;
    logic [NB_DATA-1:0]          o_dbg_data;

    modport master (
        output i_valid, i_sel_a, i_sel_b, i_wr_acc, i_op_code,
               i_wr_ram, i_rd_ram, i_operand, i_dbg_addr,
        input  o_acc, o_overflow, o_dbg_data
    );

    modport slave (
        input  i_valid, i_sel_a, i_sel_b, i_wr_acc, i_op_code,
               i_wr_ram, i_rd_ram, i_operand, i_dbg_addr,
        output o_acc, o_overflow, o_dbg_data
    );
endinterface

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/sub ALU with signed overflow,
// operand muxes and an asynchronously read data RAM.
module bip_datapath #(
    parameter int NB_DATA          = 16,
    parameter int NB_OPERAND       = 11,
    parameter int N_DATA_ADDR      = 1024,
    parameter int LOG2_N_DATA_ADDR = 10,
    parameter int NB_SEL_A         = 2
) (
    input  logic           i_clock,
    input  logic           i_reset,
    bip_datapath_if.slave  dp
);
    typedef enum logic [NB_SEL_A-1:0] {
        SEL_RAM  = 2'b00,
        SEL_IMM  = 2'b01,
        SEL_ALU  = 2'b10,
        SEL_HOLD = 2'b11
    } sel_a_t;

    logic [NB_DATA-1:0]          mem [N_DATA_ADDR];
    logic [NB_DATA-1:0]          acc;
    logic                        overflow;
    logic [LOG2_N_DATA_ADDR-1:0] addr;
    logic [NB_DATA-1:0]          imm;
    logic [NB_DATA-1:0]          ram_q;
    logic [NB_DATA-1:0]          b;
    logic [NB_DATA-1:0]          b_eff;
    logic [NB_DATA-1:0]          alu;
    logic                        ovf;
    sel_a_t                      sel_a;

    assign sel_a = sel_a_t'(dp.i_sel_a);
    assign addr  = dp.i_operand[LOG2_N_DATA_ADDR-1:0];
    assign imm   = {{(NB_DATA-NB_OPERAND){dp.i_operand[NB_OPERAND-1]}}, dp.i_operand};
    assign ram_q = dp.i_rd_ram ? mem[addr] : '0;
    assign b     = dp.i_sel_b ? imm : ram_q;

    // Subtraction overflow is judged against the inverted operand.
    always_comb begin
        b_eff = dp.i_op_code ? b : ~b;
        alu   = dp.i_op_code ? (acc + b) : (acc - b);
        ovf   = (acc[NB_DATA-1] == b_eff[NB_DATA-1]) && (alu[NB_DATA-1] != acc[NB_DATA-1]);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (dp.i_valid && dp.i_wr_acc) begin
            unique case (sel_a)
                SEL_RAM: begin
                    acc      <= ram_q;
                    overflow <= 1'b0;
                end
                SEL_IMM: begin
                    acc      <= imm;
                    overflow <= 1'b0;
                end
                SEL_ALU: begin
                    acc      <= alu;
                    overflow <= ovf;
                end
                default: ;
            endcase
        end
    end

    // Write uses the pre-edge accumulator; reset suppresses a pending store.
    always_ff @(posedge i_clock) begin
        if (!i_reset && dp.i_valid && dp.i_wr_ram)
            mem[addr] <= acc;
    end

    assign dp.o_acc      = acc;
    assign dp.o_overflow = overflow;
    assign dp.o_dbg_data = mem[dp.i_dbg_addr];
endmodule

// File: tb/tb_bip_datapath.sv
// Directed-vector bench for bip_datapath: instruction table plus hand-written
// sequences for overflow build-up, gating, reset and read-during-write.
module tb_bip_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bip_datapath_if #(.NB_DATA(16), .NB_OPERAND(11), .LOG2_N_DATA_ADDR(10), .NB_SEL_A(2)) bus ();

    bip_datapath #(
        .NB_DATA(16), .NB_OPERAND(11), .N_DATA_ADDR(1024),
        .LOG2_N_DATA_ADDR(10), .NB_SEL_A(2)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .dp      (bus.slave)
    );

    typedef struct {
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        wr_acc;
        logic        op_code;
        logic        wr_ram;
        logic        rd_ram;
        logic [10:0] operand;
        logic [15:0] exp_acc;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t tab_a [10];
    vec_t tab_b [9];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel_a, input logic sel_b, input logic wr_acc,
                         input logic op_code, input logic wr_ram, input logic rd_ram,
                         input logic [10:0] operand);
        bus.i_sel_a   = sel_a;
        bus.i_sel_b   = sel_b;
        bus.i_wr_acc  = wr_acc;
        bus.i_op_code = op_code;
        bus.i_wr_ram  = wr_ram;
        bus.i_rd_ram  = rd_ram;
        bus.i_operand = operand;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.i_valid = 1'b1;
        drive(v.sel_a, v.sel_b, v.wr_acc, v.op_code, v.wr_ram, v.rd_ram, v.operand);
        tick();
        check({v.name, "_acc"}, bus.o_acc, v.exp_acc);
        check({v.name, "_ovf"}, {15'd0, bus.o_overflow}, {15'd0, v.exp_ovf});
    endtask

    initial begin
        //            sel_a  sb wa op wr rd operand  exp_acc  ovf
        tab_a[0] = '{2'b01, 0, 1, 0, 0, 0, 11'h005, 16'h0005, 0, "ldi_5"};
        tab_a[1] = '{2'b01, 0, 1, 0, 0, 0, 11'h7FF, 16'hFFFF, 0, "ldi_7ff"};
        tab_a[2] = '{2'b01, 0, 1, 0, 0, 0, 11'h005, 16'h0005, 0, "ldi_5b"};
        tab_a[3] = '{2'b11, 0, 0, 0, 1, 0, 11'h010, 16'h0005, 0, "sto_010"};
        tab_a[4] = '{2'b01, 0, 1, 0, 0, 0, 11'h000, 16'h0000, 0, "ldi_0"};
        tab_a[5] = '{2'b00, 0, 1, 0, 0, 1, 11'h010, 16'h0005, 0, "ld_010"};
        tab_a[6] = '{2'b10, 1, 1, 1, 0, 0, 11'h003, 16'h0008, 0, "addi_3"};
        tab_a[7] = '{2'b10, 0, 1, 0, 0, 1, 11'h010, 16'h0003, 0, "sub_010"};
        tab_a[8] = '{2'b10, 1, 1, 0, 0, 0, 11'h004, 16'hFFFF, 0, "subi_4"};
        tab_a[9] = '{2'b01, 0, 1, 0, 0, 0, 11'h3FF, 16'h03FF, 0, "ldi_3ff"};

        tab_b[0] = '{2'b10, 1, 1, 1, 0, 0, 11'h001, 16'h8000, 1, "addi_1_ovf"};
        tab_b[1] = '{2'b11, 0, 1, 0, 1, 0, 11'h030, 16'h8000, 1, "hold_sto_030"};
        tab_b[2] = '{2'b10, 1, 0, 1, 0, 0, 11'h001, 16'h8000, 1, "no_wr_acc"};
        tab_b[3] = '{2'b10, 1, 1, 0, 0, 0, 11'h001, 16'h7FFF, 1, "subi_1_ovf"};
        tab_b[4] = '{2'b01, 0, 1, 0, 0, 0, 11'h005, 16'h0005, 0, "ldi_clr_ovf"};
        tab_b[5] = '{2'b00, 0, 1, 0, 0, 0, 11'h010, 16'h0000, 0, "ld_no_rd"};
        tab_b[6] = '{2'b01, 0, 1, 0, 0, 0, 11'h7FF, 16'hFFFF, 0, "ldi_neg1"};
        tab_b[7] = '{2'b10, 1, 1, 1, 0, 0, 11'h001, 16'h0000, 0, "addi_wrap"};
        tab_b[8] = '{2'b10, 0, 1, 0, 0, 1, 11'h030, 16'h8000, 1, "sub_030_ovf"};

        // Reset with active strobes.
        bus.i_valid    = 1'b1;
        bus.i_dbg_addr = 10'h010;
        drive(2'($urandom_range(0, 3)), 1'($urandom), 1'b1, 1'($urandom),
              1'($urandom), 1'($urandom), 11'($urandom));
        tick();
        tick();
        check("reset_acc", bus.o_acc, 16'h0000);
        check("reset_ovf", {15'd0, bus.o_overflow}, 16'h0000);
        rst = 1'b0;

        foreach (tab_a[i]) apply(tab_a[i]);
        check("dbg_010_after_sto", bus.o_dbg_data, 16'h0005);

        // 0x3FF + 31*0x3FF = 0x7FE0, + 0x1F = 0x7FFF
        for (int unsigned k = 0; k < 31; k++) begin
            drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h3FF);
            tick();
        end
        apply('{2'b10, 1, 1, 1, 0, 0, 11'h01F, 16'h7FFF, 0, "build_7fff"});

        foreach (tab_b[i]) apply(tab_b[i]);
        bus.i_dbg_addr = 10'h030;
        #1;
        check("dbg_030_stored", bus.o_dbg_data, 16'h8000);

        // Mid-program reset with a pending store to 0x010 and overflow set.
        bus.i_dbg_addr = 10'h010;
        rst = 1'b1;
        bus.i_valid = 1'b1;
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h010);
        tick();
        check("midrst_acc", bus.o_acc, 16'h0000);
        check("midrst_ovf", {15'd0, bus.o_overflow}, 16'h0000);
        check("midrst_ram", bus.o_dbg_data, 16'h0005);
        rst = 1'b0;

        apply('{2'b01, 0, 1, 0, 0, 0, 11'h055, 16'h0055, 0, "ldi_55"});

        // Clock-enable low: nothing commits.
        bus.i_valid = 1'b0;
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h010);
        tick();
        check("gated_acc", bus.o_acc, 16'h0055);
        check("gated_ram", bus.o_dbg_data, 16'h0005);

        // Store + load in one cycle, address upper bit ignored.
        bus.i_valid = 1'b1;
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h410);
        #1;
        check("rdw_old_word", bus.o_dbg_data, 16'h0005);
        tick();
        check("rdw_new_word", bus.o_dbg_data, 16'h0055);
        check("simul_acc", bus.o_acc, 16'hFC10);

        bus.i_wr_acc = 1'b0;
        bus.i_wr_ram = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
